// File: rtl/ddr3_pll_seq.sv
// DDR3 PLL bring-up sequencer: PLL reset, lock filtering, clock enable, controller reset release, relock on loss.
// Latency: outputs registered from next state (one edge); lock path adds two sync flops. No backpressure: pll_stop is a level request.
module ddr3_pll_seq #(
    parameter int PLL_RST_CYC  = 16,
    parameter int LOCK_FILT    = 64,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int SETTLE       = 32
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       pll_stop,
    output logic       pll_reset,
    output logic       enclk0,
    output logic       enclk2,
    output logic       ddr_rst_n,
    output logic       ready,
    output logic [7:0] relock_cnt
);

    localparam int RST_W  = (PLL_RST_CYC  > 1) ? $clog2(PLL_RST_CYC)  : 1;
    localparam int FILT_W = (LOCK_FILT    > 1) ? $clog2(LOCK_FILT)    : 1;
    localparam int TO_W   = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int SET_W  = (SETTLE       > 1) ? $clog2(SETTLE)       : 1;

    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(PLL_RST_CYC - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE - 1);

    typedef enum logic [2:0] {
        RST_PLL   = 3'd0,
        WAIT_LOCK = 3'd1,
        FILTER    = 3'd2,
        ENABLE    = 3'd3,
        RUN       = 3'd4,
        STOPPED   = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_relock;
    logic                r_lock_m;
    logic                r_lock_s;
    logic [RST_W-1:0]    r_rst_cnt;
    logic [FILT_W-1:0]   r_filt_cnt;
    logic [TO_W-1:0]     r_to_cnt;
    logic [SET_W-1:0]    r_set_cnt;
    logic                r_pll_reset;
    logic                r_enclk;
    logic                r_ddr_rst_n;
    logic                r_ready;
    logic [7:0]          r_relock_cnt;

    always_ff @(posedge clkin) begin
        if (reset) begin
            r_lock_m <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_lock_m <= pll_lock;
            r_lock_s <= r_lock_m;
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            r_state <= RST_PLL;
        end else begin
            r_state <= w_next;
        end
    end

    // Lock loss is tested before pll_stop so it always wins in RUN/STOPPED.
    always_comb begin
        w_next   = r_state;
        w_relock = 1'b0;
        case (r_state)
            RST_PLL: begin
                if (r_rst_cnt == RST_LAST) w_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (r_lock_s) begin
                    w_next = FILTER;
                end else if (r_to_cnt == TO_LAST) begin
                    w_next   = RST_PLL;
                    w_relock = 1'b1;
                end
            end
            FILTER: begin
                if (!r_lock_s)                    w_next = WAIT_LOCK;
                else if (r_filt_cnt == FILT_LAST) w_next = ENABLE;
            end
            ENABLE: begin
                if (!r_lock_s) begin
                    w_next   = RST_PLL;
                    w_relock = 1'b1;
                end else if (r_set_cnt == SET_LAST) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                if (!r_lock_s) begin
                    w_next   = RST_PLL;
                    w_relock = 1'b1;
                end else if (pll_stop) begin
                    w_next = STOPPED;
                end
            end
            STOPPED: begin
                if (!r_lock_s) begin
                    w_next   = RST_PLL;
                    w_relock = 1'b1;
                end else if (!pll_stop) begin
                    w_next = RUN;
                end
            end
            default: begin
                w_next = RST_PLL;
            end
        endcase
    end

    // Each counter runs only while its state persists and restarts at 0 on entry.
    always_ff @(posedge clkin) begin
        if (reset) begin
            r_rst_cnt  <= '0;
            r_filt_cnt <= '0;
            r_to_cnt   <= '0;
            r_set_cnt  <= '0;
        end else begin
            r_rst_cnt  <= (r_state == RST_PLL   && w_next == RST_PLL)   ? r_rst_cnt  + 1'b1 : '0;
            r_filt_cnt <= (r_state == FILTER    && w_next == FILTER)    ? r_filt_cnt + 1'b1 : '0;
            r_to_cnt   <= (r_state == WAIT_LOCK && w_next == WAIT_LOCK) ? r_to_cnt   + 1'b1 : '0;
            r_set_cnt  <= (r_state == ENABLE    && w_next == ENABLE)    ? r_set_cnt  + 1'b1 : '0;
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            r_relock_cnt <= 8'd0;
        end else if (w_relock && r_relock_cnt != 8'hFF) begin
            r_relock_cnt <= r_relock_cnt + 8'd1;
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            r_pll_reset <= 1'b1;
            r_enclk     <= 1'b0;
            r_ddr_rst_n <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_pll_reset <= (w_next == RST_PLL);
            r_enclk     <= (w_next == ENABLE) || (w_next == RUN);
            r_ddr_rst_n <= (w_next == RUN) || (w_next == STOPPED);
            r_ready     <= (w_next == RUN);
        end
    end

    assign pll_reset  = r_pll_reset;
    assign enclk0     = r_enclk;
    assign enclk2     = r_enclk;
    assign ddr_rst_n  = r_ddr_rst_n;
    assign ready      = r_ready;
    assign relock_cnt = r_relock_cnt;

endmodule

// File: doc/ddr3_pll_seq.md
DDR3_PLL_SEQ -- requirements
Module: ddr3_pll_seq

Interface
REQ-001 Parameter PLL_RST_CYC, default 16, number of cycles pll_reset is held per reset attempt (min 1).
REQ-002 Parameter LOCK_FILT, default 64, number of consecutive cycles synced lock must stay high before clocks are enabled (min 1).
REQ-003 Parameter LOCK_TIMEOUT, default 4096, number of cycles to wait for lock before re-resetting the PLL (min 1).
REQ-004 Parameter SETTLE, default 32, number of cycles between clock enable and controller reset release (min 1).
REQ-005 clkin  in  1  single clock domain, 50 MHz PLL reference; every flop is on its rising edge.
REQ-006 reset  in  1  synchronous, active-high block reset.
REQ-007 pll_lock  in  1  PLL lock, asynchronous to clkin; double-flop synchronised to lock_s before any use.
REQ-008 pll_stop  in  1  clock-stop request from the DDR3 controller, synchronous to clkin.
REQ-009 pll_reset  out  1  drives the PLL reset input.
REQ-010 enclk0  out  1  drives the PLL enclk0 input (controller clock gate).
REQ-011 enclk2  out  1  drives the PLL enclk2 input (memory clock gate).
REQ-012 ddr_rst_n  out  1  active-low reset to the DDR3 controller.
REQ-013 ready  out  1  high while clocks are locked, enabled and running.
REQ-014 relock_cnt  out  8  count of PLL re-reset events, saturating at 255.

Function
REQ-015 The FSM SHALL have the states RST_PLL, WAIT_LOCK, FILTER, ENABLE, RUN and STOPPED.
REQ-016 All outputs SHALL be registered Moore outputs decoded from the state.
REQ-017 Output decode per state:
- RST_PLL: pll_reset=1, enclk0/enclk2=0, ddr_rst_n=0, ready=0.
- WAIT_LOCK, FILTER: pll_reset=0, enclk0/enclk2=0, ddr_rst_n=0, ready=0.
- ENABLE: enclk0/enclk2=1, ddr_rst_n=0, ready=0.
- RUN: enclk0/enclk2=1, ddr_rst_n=1, ready=1.
- STOPPED: enclk0/enclk2=0, ddr_rst_n=1, ready=0.
REQ-018 RST_PLL SHALL last exactly PLL_RST_CYC cycles, then go to WAIT_LOCK with the timeout counter cleared.
REQ-019 WAIT_LOCK:
- lock_s=1 -> FILTER, with the filter counter cleared.
- PLL_LOCK_TIMEOUT cycles reached without lock -> RST_PLL and relock_cnt+1.
REQ-020 FILTER:
- The counter increments on each cycle lock_s=1.
- On the LOCK_FILT-th consecutive high cycle -> ENABLE.
- Any lock_s=0 -> WAIT_LOCK with the timeout counter cleared.
REQ-021 ENABLE SHALL last exactly SETTLE cycles, then go to RUN; lock_s=0 during ENABLE -> RST_PLL and relock_cnt+1.
REQ-022 RUN:
- lock_s=0 -> RST_PLL and relock_cnt+1.
- Otherwise pll_stop=1 -> STOPPED.
REQ-023 STOPPED:
- lock_s=0 -> RST_PLL and relock_cnt+1.
- Otherwise pll_stop=0 -> RUN.
- ddr_rst_n stays 1 throughout.
REQ-024 Lock loss SHALL take priority over pll_stop in the same cycle.
REQ-025 pll_stop SHALL be ignored in every state except RUN and STOPPED.
REQ-026 Latency from pll_lock rising:
- Let k be the first clkin edge that samples pll_lock=1.
- enclk0/enclk2 first high after edge k+2+LOCK_FILT.
- ddr_rst_n and ready first high after edge k+2+LOCK_FILT+SETTLE.
REQ-027 Latency from pll_lock falling in RUN:
- pll_reset=1 and enclk0/enclk2=0 after the 3rd clkin edge sampling pll_lock=0.
- ddr_rst_n=0 at the same edge.
REQ-028 relock_cnt SHALL saturate at 255 and never wrap.
REQ-029 The counters SHALL be sized by $clog2 of their parameter and never wrap inside a state.

Reset
REQ-030 reset=1 SHALL force the following values at the next edge, from any state:
- RST_PLL with its cycle counter cleared.
- lock sync flops 0, relock_cnt 0.
- pll_reset=1, enclk0/enclk2=0, ddr_rst_n=0, ready=0.
REQ-031 reset held high SHALL keep the block in RST_PLL with the counter at 0.
REQ-032 After reset falls, pll_reset SHALL stay high for exactly PLL_RST_CYC cycles.

Verification
REQ-033 Power-up, defaults: reset high 5 cycles, pll_lock rises 200 cycles later and stays high -> pll_reset high for 16 cycles after reset falls; enclk0/enclk2 rise at k+66; ddr_rst_n and ready rise at k+98; relock_cnt=0.
REQ-034 Lock glitch: pll_lock high 40 cycles then low 1 cycle then high -> stays in FILTER/WAIT_LOCK; enclk0/enclk2 rise 66 cycles after the second rise; pll_reset never re-asserts.
REQ-035 Lock timeout: pll_lock held low -> pll_reset re-pulses for 16 cycles every 4096+16 cycles; relock_cnt increments 1, 2, 3, ...; force 300 timeouts -> relock_cnt=255.
REQ-036 Clock stop: in RUN, pll_stop high 10 cycles -> enclk0/enclk2=0 and ready=0 for 10 cycles starting 1 cycle after pll_stop rises, ddr_rst_n=1 throughout, then RUN again.
REQ-037 Lock loss during stop: in STOPPED, pll_lock falls while pll_stop=1 -> RST_PLL after 3 edges; ddr_rst_n=0, pll_reset=1, relock_cnt+1.
REQ-038 Mid-operation reset: reset pulsed 1 cycle in RUN -> all outputs at reset values (REQ-030) next edge, relock_cnt=0, full power-up sequence repeats.
